// File: rtl/dcache_write_buffer_if.sv
// Bus bundle between the D-cache (up_*), the write buffer and the AXI bridge (dn_*).
// slave  : view used by dcache_write_buffer itself.
// master : view used by whatever drives the buffer (cache side and bridge side combined).
interface dcache_write_buffer_if;
  // Cache-side line write
  logic         up_w_valid;
  logic         up_w_ready;
  logic [31:0]  up_w_addr;
  logic [127:0] up_w_data;
  // Cache-side line refill
  logic         up_r_valid;
  logic         up_r_ready;
  logic [31:0]  up_r_addr;
  logic         up_r_resp_valid;
  logic [127:0] up_r_resp_data;
  // Bridge-side line write
  logic         dn_w_valid;
  logic         dn_w_ready;
  logic [31:0]  dn_w_addr;
  logic [127:0] dn_w_data;
  logic         dn_w_done;
  // Bridge-side line read
  logic         dn_r_valid;
  logic         dn_r_ready;
  logic [31:0]  dn_r_addr;
  logic         dn_r_resp_valid;
  logic [127:0] dn_r_resp_data;

  modport slave (
    input  up_w_valid, up_w_addr, up_w_data,
    input  up_r_valid, up_r_addr,
    input  dn_w_ready, dn_w_done,
    input  dn_r_ready, dn_r_resp_valid, dn_r_resp_data,
    output up_w_ready, up_r_ready, up_r_resp_valid, up_r_resp_data,
    output dn_w_valid, dn_w_addr, dn_w_data,
    output dn_r_valid, dn_r_addr
  );

  modport master (
    output up_w_valid, up_w_addr, up_w_data,
    output up_r_valid, up_r_addr,
    output dn_w_ready, dn_w_done,
    output dn_r_ready, dn_r_resp_valid, dn_r_resp_data,
    input  up_w_ready, up_r_ready, up_r_resp_valid, up_r_resp_data,
    input  dn_w_valid, dn_w_addr, dn_w_data,
    input  dn_r_valid, dn_r_addr
  );
endinterface

// File: rtl/dcache_write_buffer.sv
// Posted write buffer between D-cache evictions and the AXI bridge line ports.
// Accepts dirty-line writebacks, drains them to the bridge in FIFO order and
// forwards buffered lines to refills so a refill never sees stale memory.
//
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   bus       : dcache_write_buffer_if.slave (up_* cache side, dn_* bridge side)
//   wb_empty  : buffer holds no entries
//   wb_count  : number of buffered entries
//
// Build option: define WB_COALESCE_EN to merge writes into an existing,
// not-in-flight entry for the same line instead of pushing a duplicate.
module dcache_write_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  dcache_write_buffer_if.slave    bus,
  output logic                    wb_empty,
  output logic [$clog2(DEPTH):0]  wb_count
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned TAG_W  = 28;
  localparam int unsigned LINE_W = 128;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_REQ = 2'd1, W_WAIT = 2'd2} w_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_HIT = 2'd1, R_MISS = 2'd2} r_state_t;

  // Entry storage
  logic [DEPTH-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [LINE_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [CNT_W-1:0]  count_q;

  w_state_t          w_state_q;
  logic              dn_w_valid_q;
  logic [31:0]       dn_w_addr_q;
  logic [LINE_W-1:0] dn_w_data_q;

  r_state_t          r_state_q;
  logic              hit_valid_q;
  logic [LINE_W-1:0] hit_data_q;

  logic [TAG_W-1:0]  w_tag;
  logic [TAG_W-1:0]  r_tag;
  logic              w_ready;
  logic              push;
  logic              pop;
  logic              coal_wr;
  logic              c_hit;
  logic [PTR_W-1:0]  c_idx;
  logic              r_hit;
  logic [PTR_W-1:0]  r_idx;
  logic [PTR_W-1:0]  r_scan;
  logic              conflict;
  logic              r_ready;
  logic              dn_r_valid;
  logic [31:0]       dn_r_addr;
  logic              unused_low_bits;

  assign w_tag = bus.up_w_addr[31:4];
  assign r_tag = bus.up_r_addr[31:4];
  assign unused_low_bits = ^{bus.up_w_addr[3:0], bus.up_r_addr[3:0]};

  // Youngest valid entry whose tag matches the refill address
  always_comb begin
    r_hit  = 1'b0;
    r_idx  = '0;
    r_scan = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      r_scan = head_q + PTR_W'(i);
      if (valid_q[r_scan] && (tag_q[r_scan] == r_tag)) begin
        r_hit = 1'b1;
        r_idx = r_scan;
      end
    end
  end

`ifdef WB_COALESCE_EN
  logic [PTR_W-1:0] c_scan;

  // Youngest matching entry that is not the head already handed to the bridge
  always_comb begin
    c_hit  = 1'b0;
    c_idx  = '0;
    c_scan = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      c_scan = head_q + PTR_W'(i);
      if (valid_q[c_scan] && (tag_q[c_scan] == w_tag) &&
          !((c_scan == head_q) && (w_state_q != W_IDLE))) begin
        c_hit = 1'b1;
        c_idx = c_scan;
      end
    end
  end
`else
  assign c_hit = 1'b0;
  assign c_idx = '0;
`endif

  // A full buffer refuses pushes even when the head pops this cycle
  assign w_ready = (count_q < CNT_W'(DEPTH)) | c_hit;
  assign push    = bus.up_w_valid & w_ready & ~c_hit;
  assign coal_wr = bus.up_w_valid & c_hit;
  assign pop     = (w_state_q == W_WAIT) & bus.dn_w_done;

  // Tag/data payload; no reset needed, guarded by valid_q
  always_ff @(posedge clk) begin
    if (push) begin
      tag_q[tail_q]  <= w_tag;
      data_q[tail_q] <= bus.up_w_data;
    end
    if (coal_wr) begin
      data_q[c_idx] <= bus.up_w_data;
    end
  end

  // Pointers, valid bits and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Drain FSM: head stays buffered (and forwardable) until the bridge reports done
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q    <= W_IDLE;
      dn_w_valid_q <= 1'b0;
      dn_w_addr_q  <= '0;
      dn_w_data_q  <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (count_q != '0) begin
            w_state_q    <= W_REQ;
            dn_w_valid_q <= 1'b1;
            dn_w_addr_q  <= {tag_q[head_q], 4'b0000};
            // A write merging into the head this very cycle must be what goes out
            dn_w_data_q  <= (coal_wr && (c_idx == head_q)) ? bus.up_w_data : data_q[head_q];
          end
        end
        W_REQ: begin
          if (bus.dn_w_ready) begin
            w_state_q    <= W_WAIT;
            dn_w_valid_q <= 1'b0;
          end
        end
        W_WAIT: begin
          if (bus.dn_w_done) begin
            w_state_q <= W_IDLE;
          end
        end
        default: begin
          w_state_q    <= W_IDLE;
          dn_w_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Same-line write in the same cycle wins; the read retries against new contents
  assign conflict = bus.up_w_valid & bus.up_r_valid & (w_tag == r_tag);

  // Refill acceptance and miss request toward the bridge
  always_comb begin
    r_ready    = 1'b0;
    dn_r_valid = 1'b0;
    dn_r_addr  = '0;
    if ((r_state_q == R_IDLE) && bus.up_r_valid && !conflict) begin
      if (r_hit) begin
        r_ready = 1'b1;
      end else begin
        dn_r_valid = 1'b1;
        dn_r_addr  = {r_tag, 4'b0000};
        r_ready    = bus.dn_r_ready;
      end
    end
  end

  // Read FSM: one refill outstanding at a time
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q   <= R_IDLE;
      hit_valid_q <= 1'b0;
      hit_data_q  <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (r_ready) begin
            if (r_hit) begin
              r_state_q   <= R_HIT;
              hit_valid_q <= 1'b1;
              hit_data_q  <= data_q[r_idx];
            end else begin
              r_state_q <= R_MISS;
            end
          end
        end
        R_HIT: begin
          r_state_q   <= R_IDLE;
          hit_valid_q <= 1'b0;
          hit_data_q  <= '0;
        end
        R_MISS: begin
          if (bus.dn_r_resp_valid) begin
            r_state_q <= R_IDLE;
          end
        end
        default: begin
          r_state_q   <= R_IDLE;
          hit_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Outputs
  assign bus.up_w_ready      = w_ready;
  assign bus.up_r_ready      = r_ready;
  assign bus.dn_r_valid      = dn_r_valid;
  assign bus.dn_r_addr       = dn_r_addr;
  assign bus.dn_w_valid      = dn_w_valid_q;
  assign bus.dn_w_addr       = dn_w_addr_q;
  assign bus.dn_w_data       = dn_w_data_q;
  assign bus.up_r_resp_valid = hit_valid_q |
                               ((r_state_q == R_MISS) & bus.dn_r_resp_valid);
  assign bus.up_r_resp_data  = hit_valid_q ? hit_data_q :
                               (((r_state_q == R_MISS) && bus.dn_r_resp_valid) ?
                                bus.dn_r_resp_data : '0);
  assign wb_count            = count_q;
  assign wb_empty            = (count_q == '0);

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Directed bench for dcache_write_buffer (DEPTH = 4): a vector table for the
// push/drain path plus hand-written sequences for refills and corner cases.
module tb_dcache_write_buffer;

  logic       clk;
  logic       rst;
  logic       wb_empty;
  logic [2:0] wb_count;
  int         n_vec;
  int         n_fail;

  dcache_write_buffer_if bus ();

  dcache_write_buffer #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .wb_empty (wb_empty),
    .wb_count (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] D110 = 128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC;
  localparam logic [127:0] D120 = 128'h12121212_23232323_34343434_45454545;
  localparam logic [127:0] D130 = 128'h77777777_66666666_55555555_44444444;
  localparam logic [127:0] D140 = 128'h40404040_41414141_42424242_43434343;
  localparam logic [127:0] D150 = 128'h50505050_51515151_52525252_53535353;
  localparam logic [127:0] D200 = 128'h33333333_22222222_11111111_00000000;
  localparam logic [127:0] DNEW = 128'hABCDEF01_23456789_ABCDEF01_23456789;
  localparam logic [127:0] DA   = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA;
  localparam logic [127:0] DB   = 128'hBBBBBBBB_BBBBBBBB_BBBBBBBB_BBBBBBBB;

  typedef struct {
    string        name;
    logic         wv;
    logic [31:0]  wa;
    logic [127:0] wd;
    logic         dwr;
    logic         dwd;
    logic [2:0]   ecnt;
    logic         ewr;
    logic         edwv;
    logic [31:0]  eaddr;
    logic [127:0] edata;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input string n, input logic wv, input logic [31:0] wa,
                              input logic [127:0] wd, input logic dwr, input logic dwd,
                              input logic [2:0] ec, input logic ewr, input logic edwv,
                              input logic [31:0] ea, input logic [127:0] ed);
    vec_t v;
    v.name = n; v.wv = wv; v.wa = wa; v.wd = wd; v.dwr = dwr; v.dwd = dwd;
    v.ecnt = ec; v.ewr = ewr; v.edwv = edwv; v.eaddr = ea; v.edata = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.up_w_valid = 1'b0; bus.up_w_addr = '0; bus.up_w_data = '0;
    bus.up_r_valid = 1'b0; bus.up_r_addr = '0;
    bus.dn_w_ready = 1'b0; bus.dn_w_done = 1'b0;
    bus.dn_r_ready = 1'b0; bus.dn_r_resp_valid = 1'b0; bus.dn_r_resp_data = '0;
  endtask

  task automatic push(input logic [31:0] a, input logic [127:0] d);
    @(negedge clk);
    bus.up_w_valid = 1'b1; bus.up_w_addr = a; bus.up_w_data = d;
    @(negedge clk);
    bus.up_w_valid = 1'b0;
  endtask

  // Release the bridge, expect the next write to be (a, d), then return done
  task automatic drain_expect(input string nm, input logic [31:0] a, input logic [127:0] d);
    int n;
    n = 0;
    @(negedge clk);
    bus.dn_w_ready = 1'b1;
    #1;
    while (!bus.dn_w_valid && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(nm, 256'({bus.dn_w_valid, bus.dn_w_addr, bus.dn_w_data}), 256'({1'b1, a, d}));
    @(negedge clk);
    bus.dn_w_ready = 1'b0;
    bus.dn_w_done  = 1'b1;
    @(negedge clk);
    bus.dn_w_done  = 1'b0;
  endtask

  // Hit read: accept now, response next cycle
  task automatic read_hit(input string nm, input logic [31:0] a, input logic [127:0] d);
    @(negedge clk);
    bus.up_r_valid = 1'b1; bus.up_r_addr = a;
    #1;
    chk({nm, "_accept"}, 256'({bus.up_r_ready, bus.dn_r_valid}), 256'({1'b1, 1'b0}));
    @(negedge clk);
    bus.up_r_valid = 1'b0;
    #1;
    chk({nm, "_resp"}, 256'({bus.up_r_resp_valid, bus.up_r_resp_data, bus.dn_r_valid}),
        256'({1'b1, d, 1'b0}));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec  = 0;
    n_fail = 0;
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    //         name          wv  wa      wd    dwr  dwd  cnt  wr   dwv  addr    data
    vq.push_back(mk("rst_state", 0, 32'h0,   '0,   0,   0,   0,   1,   0,   32'h0,  '0));
    vq.push_back(mk("push110",   1, 32'h110, D110, 1,   0,   0,   1,   0,   32'h0,  '0));
    vq.push_back(mk("cnt1",      0, 32'h0,   '0,   1,   0,   1,   1,   0,   32'h0,  '0));
    vq.push_back(mk("dnw110",    0, 32'h0,   '0,   1,   0,   1,   1,   1,   32'h110, D110));
    vq.push_back(mk("wait_done", 0, 32'h0,   '0,   1,   0,   1,   1,   0,   32'h0,  '0));
    vq.push_back(mk("done110",   0, 32'h0,   '0,   0,   1,   1,   1,   0,   32'h0,  '0));
    vq.push_back(mk("empty1",    0, 32'h0,   '0,   0,   0,   0,   1,   0,   32'h0,  '0));
    vq.push_back(mk("f_push110", 1, 32'h110, D110, 0,   0,   0,   1,   0,   32'h0,  '0));
    vq.push_back(mk("f_push120", 1, 32'h120, D120, 0,   0,   1,   1,   0,   32'h0,  '0));
    vq.push_back(mk("f_push130", 1, 32'h130, D130, 0,   0,   2,   1,   1,   32'h110, D110));
    vq.push_back(mk("f_push140", 1, 32'h140, D140, 0,   0,   3,   1,   1,   32'h110, D110));
    vq.push_back(mk("full",      1, 32'h150, D150, 0,   0,   4,   0,   1,   32'h110, D110));
    vq.push_back(mk("rel110",    0, 32'h0,   '0,   1,   0,   4,   0,   1,   32'h110, D110));
    vq.push_back(mk("full_pop",  1, 32'h150, D150, 0,   1,   4,   0,   0,   32'h0,  '0));
    vq.push_back(mk("idle3",     0, 32'h0,   '0,   1,   0,   3,   1,   0,   32'h0,  '0));
    vq.push_back(mk("req120",    0, 32'h0,   '0,   1,   0,   3,   1,   1,   32'h120, D120));
    vq.push_back(mk("done120",   0, 32'h0,   '0,   0,   1,   3,   1,   0,   32'h0,  '0));
    vq.push_back(mk("idle2",     0, 32'h0,   '0,   1,   0,   2,   1,   0,   32'h0,  '0));
    vq.push_back(mk("req130",    0, 32'h0,   '0,   1,   0,   2,   1,   1,   32'h130, D130));
    vq.push_back(mk("done130",   0, 32'h0,   '0,   0,   1,   2,   1,   0,   32'h0,  '0));
    vq.push_back(mk("idle1",     0, 32'h0,   '0,   1,   0,   1,   1,   0,   32'h0,  '0));
    vq.push_back(mk("req140",    0, 32'h0,   '0,   1,   0,   1,   1,   1,   32'h140, D140));
    vq.push_back(mk("done140",   0, 32'h0,   '0,   0,   1,   1,   1,   0,   32'h0,  '0));
    vq.push_back(mk("empty2",    0, 32'h0,   '0,   0,   0,   0,   1,   0,   32'h0,  '0));

    foreach (vq[i]) begin
      @(negedge clk);
      bus.up_w_valid = vq[i].wv; bus.up_w_addr = vq[i].wa; bus.up_w_data = vq[i].wd;
      bus.dn_w_ready = vq[i].dwr; bus.dn_w_done = vq[i].dwd;
      #1;
      chk(vq[i].name,
          256'({wb_count, wb_empty, bus.up_w_ready, bus.dn_w_valid,
                vq[i].edwv ? bus.dn_w_addr : 32'h0, vq[i].edwv ? bus.dn_w_data : 128'h0,
                bus.up_r_ready, bus.dn_r_valid, bus.up_r_resp_valid}),
          256'({vq[i].ecnt, (vq[i].ecnt == 3'd0), vq[i].ewr, vq[i].edwv,
                vq[i].eaddr, vq[i].edata, 1'b0, 1'b0, 1'b0}));
    end
    idle_inputs();

    // Forward a buffered line while the drain is stalled
    push(32'h130, D130);
    repeat (2) @(negedge clk);
    read_hit("hit134", 32'h134, D130);
    @(negedge clk);
    #1;
    chk("hit_pulse_end", 256'({bus.up_r_resp_valid, bus.dn_r_valid}), 256'({1'b0, 1'b0}));
    drain_expect("hit_drain", 32'h130, D130);

    // Miss goes to the bridge; response passes straight through
    @(negedge clk);
    bus.up_r_valid = 1'b1; bus.up_r_addr = 32'h200; bus.dn_r_ready = 1'b1;
    #1;
    chk("miss_req", 256'({bus.dn_r_valid, bus.dn_r_addr, bus.up_r_ready}),
        256'({1'b1, 32'h200, 1'b1}));
    @(negedge clk);
    bus.up_r_addr = 32'h300;
    #1;
    chk("miss_busy", 256'({bus.up_r_ready, bus.dn_r_valid, bus.up_r_resp_valid}),
        256'({1'b0, 1'b0, 1'b0}));
    @(negedge clk);
    bus.up_r_valid = 1'b0;
    bus.dn_r_resp_valid = 1'b1; bus.dn_r_resp_data = D200;
    #1;
    chk("miss_resp", 256'({bus.up_r_resp_valid, bus.up_r_resp_data}), 256'({1'b1, D200}));
    @(negedge clk);
    bus.dn_r_resp_valid = 1'b0; bus.dn_r_resp_data = '0; bus.dn_r_ready = 1'b0;
    #1;
    chk("miss_idle", 256'({bus.up_r_resp_valid, bus.up_r_ready, bus.up_r_resp_data}),
        256'({1'b0, 1'b0, 128'h0}));

    // Same-cycle write and read of one line: read waits and sees the new data
    push(32'h120, D120);
    repeat (2) @(negedge clk);
    @(negedge clk);
    bus.up_w_valid = 1'b1; bus.up_w_addr = 32'h120; bus.up_w_data = DNEW;
    bus.up_r_valid = 1'b1; bus.up_r_addr = 32'h128;
    #1;
    chk("conf_stall", 256'({bus.up_r_ready, bus.up_w_ready, bus.dn_r_valid}),
        256'({1'b0, 1'b1, 1'b0}));
    @(negedge clk);
    bus.up_w_valid = 1'b0;
    #1;
    chk("conf_accept", 256'({bus.up_r_ready, wb_count}), 256'({1'b1, 3'd2}));
    @(negedge clk);
    bus.up_r_valid = 1'b0;
    #1;
    chk("conf_resp", 256'({bus.up_r_resp_valid, bus.up_r_resp_data}), 256'({1'b1, DNEW}));
    drain_expect("conf_drain_old", 32'h120, D120);
    drain_expect("conf_drain_new", 32'h120, DNEW);

    // Two writes to one line with the drain stalled
`ifdef WB_COALESCE_EN
    push(32'h160, D150);
    repeat (2) @(negedge clk);
    push(32'h150, DA);
    push(32'h150, DB);
    #1;
    chk("dup_count", 256'(wb_count), 256'(3'd2));
    read_hit("dup_read", 32'h150, DB);
    drain_expect("dup_drain_head", 32'h160, D150);
    drain_expect("dup_drain_b", 32'h150, DB);
`else
    push(32'h150, DA);
    push(32'h150, DB);
    #1;
    chk("dup_count", 256'(wb_count), 256'(3'd2));
    read_hit("dup_read", 32'h150, DB);
    drain_expect("dup_drain_a", 32'h150, DA);
    drain_expect("dup_drain_b", 32'h150, DB);
`endif
    @(negedge clk);
    #1;
    chk("dup_empty", 256'({wb_count, wb_empty}), 256'({3'd0, 1'b1}));

    // Reset while a bridge write is pending discards everything
    push(32'h170, D150);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pre", 256'({bus.dn_w_valid, wb_count}), 256'({1'b1, 3'd1}));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid", 256'({wb_count, wb_empty, bus.dn_w_valid, bus.up_w_ready, bus.dn_w_addr}),
        256'({3'd0, 1'b1, 1'b0, 1'b1, 32'h0}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
